serial_wb_mcu: RTL and testbench

//  Tiny 8-bit controller for the serial Wishbone logic-analyzer front end.

---
 rtl/serial_wb_mcu.sv | 221 ++++++++++++++++++++++
 tb/tb_serial_wb_mcu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_wb_mcu.sv
// serial_wb_mcu
//   Tiny 8-bit controller for the serial Wishbone logic-analyzer front end.
//   Executes 16-bit instructions fetched from a 512-word synchronous program
//   memory (one clock read latency). It has a 16x8 register file, Z/C flags,
//   two registered output ports with one-cycle write strobes and one input port.
//
//   Optional feature macro: SERIAL_WB_MCU_PORT1_EN
//     defined     : "out" with d=1 drives port1_o / strobe1_o
//     not defined : port1_o and strobe1_o are tied to 0, "out" with d=1 is a nop
//
// Ports
//   clk_i      in   1   clock, rising edge
//   rst_ni     in   1   asynchronous active-low reset
//   pm_addr_o  out  9   program memory word address (combinational next-PC)
//   pm_insn_i  in   16  program memory data for the previous cycle's pm_addr_o
//   port0_o    out  8   output port 0 (registered)
//   strobe0_o  out  1   one-cycle pulse after port0_o is written
//   port1_o    out  8   output port 1 (registered)
//   strobe1_o  out  1   one-cycle pulse after port1_o is written
//   port2_i    in   8   input port 2
//
// Instruction fields: op=[15:12] d=[11:8] a=[7:4] b=[3:0] imm=[7:0]
//                     cond=[11:9] tgt=[8:0]
module serial_wb_mcu #(
    parameter logic [8:0] RESET_PC = 9'h000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [8:0]  pm_addr_o,
    input  logic [15:0] pm_insn_i,
    output logic [7:0]  port0_o,
    output logic        strobe0_o,
    output logic [7:0]  port1_o,
    output logic        strobe1_o,
    input  logic [7:0]  port2_i
);

    typedef enum logic [1:0] {
        ST_BUBBLE = 2'd0,  // first cycle after reset, fetch of RESET_PC in flight
        ST_EXEC   = 2'd1,  // pm_insn_i is the instruction at pc
        ST_LDDATA = 2'd2   // pm_insn_i is the data word requested by ld
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic [7:0]  port0_q, port0_d;
    logic        strobe0_q, strobe0_d;
    logic [3:0]  ld_rd_q, ld_rd_d;
    logic        ld_lo_q, ld_lo_d;

`ifdef SERIAL_WB_MCU_PORT1_EN
    logic [7:0]  port1_q, port1_d;
    logic        strobe1_q, strobe1_d;
`endif

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [7:0]  ra_val;
    logic [7:0]  rb_val;
    logic [8:0]  pc_inc;
    logic [8:0]  sum;
    logic [7:0]  res;
    logic        taken;
    logic [8:0]  pm_addr;

    assign op     = pm_insn_i[15:12];
    assign rd     = pm_insn_i[11:8];
    assign ra_val = regs_q[pm_insn_i[7:4]];
    assign rb_val = regs_q[pm_insn_i[3:0]];
    assign pc_inc = pc_q + 9'd1;  // wraps 1FF -> 000

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        regs_d    = regs_q;
        z_d       = z_q;
        c_d       = c_q;
        port0_d   = port0_q;
        strobe0_d = 1'b0;
        ld_rd_d   = ld_rd_q;
        ld_lo_d   = ld_lo_q;
`ifdef SERIAL_WB_MCU_PORT1_EN
        port1_d   = port1_q;
        strobe1_d = 1'b0;
`endif
        pm_addr   = pc_inc;
        sum       = 9'd0;
        res       = 8'd0;
        taken     = 1'b0;

        case (state_q)
            ST_BUBBLE: begin
                pm_addr = RESET_PC;
                pc_d    = RESET_PC;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                pc_d = pc_inc;
                case (op)
                    4'h0: begin
                        sum        = {1'b0, ra_val} + {1'b0, rb_val};
                        regs_d[rd] = sum[7:0];
                        c_d        = sum[8];
                        z_d        = (sum[7:0] == 8'd0);
                    end
                    4'h1, 4'h2, 4'h3: begin
                        if (op == 4'h1)      res = ra_val ^ rb_val;
                        else if (op == 4'h2) res = ra_val & rb_val;
                        else                 res = ra_val | rb_val;
                        regs_d[rd] = res;
                        c_d        = 1'b0;
                        z_d        = (res == 8'd0);
                    end
                    4'h4: regs_d[rd] = pm_insn_i[7:0];
                    4'h5: regs_d[rd] = port2_i;
                    4'h6: begin
                        // Data window is the top of PM (0x180-0x1FF); each word
                        // holds two bytes, ra[0] selects the byte next cycle.
                        pm_addr = {2'b11, ra_val[7:1]};
                        pc_d    = pc_q;
                        ld_rd_d = rd;
                        ld_lo_d = ra_val[0];
                        state_d = ST_LDDATA;
                    end
                    4'h7: regs_d[rd] = {ra_val[3:0], ra_val[7:4]};
                    4'h8: begin
                        case (pm_insn_i[11:9])
                            3'b000:  taken = 1'b1;
                            3'b001:  taken = z_q;
                            3'b010:  taken = ~z_q;
                            3'b011:  taken = c_q;
                            3'b100:  taken = ~c_q;
                            default: taken = 1'b0;
                        endcase
                        // Target goes straight onto the PM address so a taken
                        // jump costs no extra cycle.
                        if (taken) begin
                            pm_addr = pm_insn_i[8:0];
                            pc_d    = pm_insn_i[8:0];
                        end
                    end
                    4'h9: begin
                        if (rd == 4'd0) begin
                            port0_d   = ra_val;
                            strobe0_d = 1'b1;
                        end
`ifdef SERIAL_WB_MCU_PORT1_EN
                        if (rd == 4'd1) begin
                            port1_d   = ra_val;
                            strobe1_d = 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end

            ST_LDDATA: begin
                regs_d[ld_rd_q] = ld_lo_q ? pm_insn_i[7:0] : pm_insn_i[15:8];
                pm_addr         = pc_inc;
                pc_d            = pc_inc;
                state_d         = ST_EXEC;
            end

            default: begin
                pm_addr = RESET_PC;
                pc_d    = RESET_PC;
                state_d = ST_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_BUBBLE;
            pc_q      <= RESET_PC;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            port0_q   <= 8'd0;
            strobe0_q <= 1'b0;
            ld_rd_q   <= 4'd0;
            ld_lo_q   <= 1'b0;
`ifdef SERIAL_WB_MCU_PORT1_EN
            port1_q   <= 8'd0;
            strobe1_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
            z_q       <= z_d;
            c_q       <= c_d;
            port0_q   <= port0_d;
            strobe0_q <= strobe0_d;
            ld_rd_q   <= ld_rd_d;
            ld_lo_q   <= ld_lo_d;
`ifdef SERIAL_WB_MCU_PORT1_EN
            port1_q   <= port1_d;
            strobe1_q <= strobe1_d;
`endif
        end
    end

    assign pm_addr_o = pm_addr;
    assign port0_o   = port0_q;
    assign strobe0_o = strobe0_q;
`ifdef SERIAL_WB_MCU_PORT1_EN
    assign port1_o   = port1_q;
    assign strobe1_o = strobe1_q;
`else
    assign port1_o   = 8'd0;
    assign strobe1_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_wb_mcu.sv
// Directed bench for serial_wb_mcu: a synchronous PM model, a strobe monitor
// that records every port write with the cycle it appeared in, and a linear
// sequence of programs with hand-computed port0 traces.
module tb_serial_wb_mcu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [8:0]  pm_addr_o;
    logic [15:0] pm_insn_i;
    logic [7:0]  port0_o;
    logic        strobe0_o;
    logic [7:0]  port1_o;
    logic        strobe1_o;
    logic [7:0]  port2_i;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_wb_mcu dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .pm_addr_o (pm_addr_o),
        .pm_insn_i (pm_insn_i),
        .port0_o   (port0_o),
        .strobe0_o (strobe0_o),
        .port1_o   (port1_o),
        .strobe1_o (strobe1_o),
        .port2_i   (port2_i)
    );

    // ---------------- clock / PM model / cycle counter ----------------
    always #5 clk_i = ~clk_i;

    logic [15:0] pm [0:511];
    always @(posedge clk_i) pm_insn_i <= pm[pm_addr_o];

    // cyc=n while the n-th instruction slot after reset release is executing
    int cyc;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // ---------------- strobe monitor / scoreboard ----------------
    logic [7:0] cap0_q[$];
    int         cap0_cyc_q[$];
    logic [7:0] cap1_q[$];
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (strobe0_o) begin
                cap0_q.push_back(port0_o);
                cap0_cyc_q.push_back(cyc);
            end
            if (strobe1_o) cap1_q.push_back(port1_o);
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] i_rrr(input logic [3:0] op, input logic [3:0] d,
                                          input logic [3:0] a, input logic [3:0] b);
        return {op, d, a, b};
    endfunction
    function automatic logic [15:0] i_set(input logic [3:0] d, input logic [7:0] imm);
        return {4'h4, d, imm};
    endfunction
    function automatic logic [15:0] i_in2(input logic [3:0] d);
        return {4'h5, d, 8'h00};
    endfunction
    function automatic logic [15:0] i_ld(input logic [3:0] d, input logic [3:0] a);
        return {4'h6, d, a, 4'h0};
    endfunction
    function automatic logic [15:0] i_swap(input logic [3:0] d, input logic [3:0] a);
        return {4'h7, d, a, 4'h0};
    endfunction
    function automatic logic [15:0] i_jmp(input logic [2:0] cond, input logic [8:0] tgt);
        return {4'h8, cond, tgt};
    endfunction
    function automatic logic [15:0] i_out(input logic [3:0] p, input logic [3:0] a);
        return {4'h9, p, a, 4'h0};
    endfunction

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pm();
        for (int i = 0; i < 512; i++) pm[i] = 16'hF000;  // nop
    endtask

    task automatic hold_reset();
        rst_ni = 1'b0;
        cap0_q.delete();
        cap0_cyc_q.delete();
        cap1_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic expect0(input logic [7:0] v, input int c);
        exp_q.push_back(v);
        exp_cyc_q.push_back(c);
    endtask

    task automatic compare_port0(input string tag);
        logic [7:0]  obs_v;
        logic [31:0] obs_c;
        check({tag, " strobe count"}, cap0_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_v = (i < cap0_q.size()) ? cap0_q[i] : 8'hxx;
            obs_c = (i < cap0_cyc_q.size()) ? cap0_cyc_q[i] : 32'hFFFF_FFFF;
            check($sformatf("%s value[%0d]", tag, i), {24'd0, obs_v}, {24'd0, exp_q[i]});
            check($sformatf("%s cycle[%0d]", tag, i), obs_c, exp_cyc_q[i]);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_ni  = 1'b0;
        port2_i = 8'hAB;
        clear_pm();

        // Reset state
        hold_reset();
        check("reset pm_addr", {23'd0, pm_addr_o}, 32'h000);
        check("reset port0", {24'd0, port0_o}, 32'h00);
        check("reset strobe0", {31'd0, strobe0_o}, 32'h0);
        check("reset port1", {24'd0, port1_o}, 32'h00);
        check("reset strobe1", {31'd0, strobe1_o}, 32'h0);

        // T1: set r0..r15 then out0 each; strobes on consecutive cycles
        for (int i = 0; i < 16; i++) begin
            logic [3:0] k;
            k = i[3:0];
            pm[i]      = i_set(k, {k, ~k});
            pm[16 + i] = i_out(4'd0, k);
            expect0({k, ~k}, 18 + i);
        end
        pm[32] = i_jmp(3'b000, 9'd32);
        release_reset();
        #1 check("bubble pm_addr", {23'd0, pm_addr_o}, 32'h000);
        wait_cycles(40);
        compare_port0("regfile");

        // T2: ALU, flags, in2, never-taken cond, port1
        hold_reset();
        clear_pm();
        pm[0]  = i_set(4'd0, 8'hA0);
        pm[1]  = i_set(4'd1, 8'h75);
        pm[2]  = i_set(4'd2, 8'h01);
        pm[3]  = i_rrr(4'h0, 4'd4, 4'd0, 4'd1);  // 15, C=1
        pm[4]  = i_jmp(3'b011, 9'd6);            // C=1 taken
        pm[5]  = i_out(4'd0, 4'd0);
        pm[6]  = i_out(4'd0, 4'd4);
        pm[7]  = i_rrr(4'h0, 4'd5, 4'd1, 4'd2);  // 76, C=0
        pm[8]  = i_jmp(3'b100, 9'd10);           // C=0 taken
        pm[9]  = i_out(4'd0, 4'd0);
        pm[10] = i_out(4'd0, 4'd5);
        pm[11] = i_rrr(4'h1, 4'd6, 4'd0, 4'd1);  // D5
        pm[12] = i_out(4'd0, 4'd6);
        pm[13] = i_rrr(4'h1, 4'd7, 4'd0, 4'd2);  // A1
        pm[14] = i_out(4'd0, 4'd7);
        pm[15] = i_rrr(4'h2, 4'd8, 4'd0, 4'd1);  // 20
        pm[16] = i_out(4'd0, 4'd8);
        pm[17] = i_rrr(4'h2, 4'd9, 4'd0, 4'd2);  // 00, Z=1
        pm[18] = i_jmp(3'b001, 9'd20);           // Z=1 taken
        pm[19] = i_out(4'd0, 4'd0);
        pm[20] = i_out(4'd0, 4'd9);
        pm[21] = i_rrr(4'h3, 4'd10, 4'd0, 4'd1); // F5
        pm[22] = i_out(4'd0, 4'd10);
        pm[23] = i_rrr(4'h3, 4'd11, 4'd0, 4'd2); // A1, C=0
        pm[24] = i_out(4'd0, 4'd11);
        pm[25] = i_jmp(3'b011, 9'd27);           // C=0 -> not taken
        pm[26] = i_out(4'd0, 4'd0);              // A0
        pm[27] = i_in2(4'd12);
        pm[28] = i_out(4'd0, 4'd12);             // AB
        pm[29] = i_jmp(3'b101, 9'd31);           // never taken
        pm[30] = i_out(4'd0, 4'd2);              // 01
        pm[31] = i_out(4'd1, 4'd0);              // port1 <- A0 when enabled
        pm[32] = i_out(4'd5, 4'd0);              // nop
        pm[33] = i_jmp(3'b000, 9'd33);
        expect0(8'h15, 7);
        expect0(8'h76, 10);
        expect0(8'hD5, 12);
        expect0(8'hA1, 14);
        expect0(8'h20, 16);
        expect0(8'h00, 19);
        expect0(8'hF5, 21);
        expect0(8'hA1, 23);
        expect0(8'hA0, 25);
        expect0(8'hAB, 27);
        expect0(8'h01, 29);
        release_reset();
        wait_cycles(40);
        compare_port0("alu");
`ifdef SERIAL_WB_MCU_PORT1_EN
        check("port1 strobes", cap1_q.size(), 32'd1);
        check("port1 value", {24'd0, port1_o}, 32'hA0);
`else
        check("port1 strobes", cap1_q.size(), 32'd0);
        check("port1 value", {24'd0, port1_o}, 32'h00);
`endif

        // T3: ld high/low byte with one stall each, then swap
        hold_reset();
        clear_pm();
        pm[9'h1F0] = 16'hBEEF;
        pm[0]  = i_set(4'd0, 8'hE0);
        pm[1]  = i_set(4'd1, 8'hE1);
        pm[2]  = i_ld(4'd2, 4'd0);
        pm[3]  = i_ld(4'd3, 4'd1);
        pm[4]  = i_out(4'd0, 4'd2);
        pm[5]  = i_out(4'd0, 4'd3);
        pm[6]  = i_set(4'd4, 8'hF0);
        pm[7]  = i_swap(4'd5, 4'd4);
        pm[8]  = i_out(4'd0, 4'd5);
        pm[9]  = i_jmp(3'b000, 9'd9);
        expect0(8'hBE, 8);
        expect0(8'hEF, 9);
        expect0(8'h0F, 12);
        release_reset();
        wait_cycles(3);
        check("ld exec pm_addr", {23'd0, pm_addr_o}, 32'h1F0);
        wait_cycles(1);
        check("ld data pm_addr", {23'd0, pm_addr_o}, 32'h003);
        wait_cycles(16);
        compare_port0("ld");

        // T4: taken jump over three outs, no lost cycle
        hold_reset();
        clear_pm();
        pm[0] = i_set(4'd0, 8'hFE);
        pm[1] = i_jmp(3'b000, 9'd5);
        pm[2] = i_out(4'd0, 4'd1);
        pm[3] = i_out(4'd0, 4'd1);
        pm[4] = i_out(4'd0, 4'd1);
        pm[5] = i_out(4'd0, 4'd0);
        pm[6] = i_jmp(3'b000, 9'd6);
        expect0(8'hFE, 4);
        release_reset();
        wait_cycles(2);
        check("jmp pm_addr", {23'd0, pm_addr_o}, 32'h005);
        wait_cycles(10);
        compare_port0("jump");

        // T5: beq not taken then taken
        hold_reset();
        clear_pm();
        pm[0]  = i_set(4'd0, 8'h40);
        pm[1]  = i_rrr(4'h0, 4'd0, 4'd0, 4'd0);  // 80, Z=0
        pm[2]  = i_jmp(3'b001, 9'd5);
        pm[3]  = i_out(4'd0, 4'd0);
        pm[4]  = i_out(4'd0, 4'd0);
        pm[5]  = i_rrr(4'h0, 4'd0, 4'd0, 4'd0);  // 00, Z=1
        pm[6]  = i_out(4'd0, 4'd0);
        pm[7]  = i_jmp(3'b001, 9'd10);
        pm[8]  = i_out(4'd0, 4'd1);
        pm[9]  = i_out(4'd0, 4'd1);
        pm[10] = i_set(4'd3, 8'hDF);
        pm[11] = i_out(4'd0, 4'd3);
        pm[12] = i_jmp(3'b000, 9'd12);
        expect0(8'h80, 5);
        expect0(8'h80, 6);
        expect0(8'h00, 8);
        expect0(8'hDF, 11);
        release_reset();
        wait_cycles(18);
        compare_port0("beq");

        // T6: pc wraps 1FF -> 000
        hold_reset();
        clear_pm();
        pm[0]      = i_jmp(3'b000, 9'h1FE);
        pm[9'h1FE] = i_set(4'd1, 8'h77);
        pm[9'h1FF] = i_out(4'd0, 4'd1);
        expect0(8'h77, 4);
        expect0(8'h77, 7);
        release_reset();
        wait_cycles(3);
        check("wrap pm_addr", {23'd0, pm_addr_o}, 32'h000);
        wait_cycles(5);
        compare_port0("wrap");

        // T7: reset in the middle of an ld
        hold_reset();
        clear_pm();
        pm[0] = i_set(4'd0, 8'hE0);
        pm[1] = i_out(4'd0, 4'd0);
        pm[2] = i_ld(4'd2, 4'd0);
        pm[3] = i_jmp(3'b000, 9'd3);
        release_reset();
        wait_cycles(4);
        check("pre-abort port0", {24'd0, port0_o}, 32'hE0);
        rst_ni = 1'b0;
        #1;
        check("abort pm_addr", {23'd0, pm_addr_o}, 32'h000);
        check("abort port0", {24'd0, port0_o}, 32'h00);
        check("abort strobe0", {31'd0, strobe0_o}, 32'h0);
        hold_reset();
        clear_pm();
        pm[0] = i_out(4'd0, 4'd2);
        pm[1] = i_out(4'd0, 4'd0);
        pm[2] = i_jmp(3'b000, 9'd2);
        expect0(8'h00, 2);
        expect0(8'h00, 3);
        release_reset();
        wait_cycles(8);
        compare_port0("post-abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
